cdd_timer_ctrl: RTL and testbench
=================================

Name: cdd_timer_ctrl

Overview:
- Control stage directly upstream of the 8-bit BCD down counter (two BCD digits, 00–99).
- Generates the counter's LD, EN, CAI tick and clear strobes from a prescaled clock.
- Latches a BCD preset and watches the counter's CAO to detect terminal count.
- Produces a one-shot/auto-reload countdown timer with pause, abort and a DONE pulse.

Parameters:
- PRESCALE, default 10: CLK cycles per count tick; legal range 1..65535.
- PW, default 16: prescaler counter width; must satisfy 2**PW >= PRESCALE.

Ports:
- CLK  in  1  rising-edge clock.
- RSTN  in  1  reset, synchronous, active-low.
- START  in  1  level, sampled each edge; starts or restarts the timer with PRESET.
- STOP  in  1  level; aborts and clears the counter; highest priority after reset.
- PAUSE  in  1  level; freezes counting while high.
- AUTO_RELOAD  in  1  sampled together with START; reload on expiry when latched high.
- PRESET  in  8  BCD preset; [7:4] tens, [3:0] units.
- CAO  in  1  counter carry-out; high when CAI and EN are high and Q=00.
- D  out  8  latched preset (preset_r) to the counter's D inputs.
- LD  out  1  counter parallel load.
- EN  out  1  counter enable.
- CAI  out  1  count tick; one CLK cycle wide.
- CLR  out  1  counter clear request, active-high.
- DONE  out  1  one-cycle expiry pulse.
- BUSY  out  1  high when state is not IDLE or ABORT.
- ERR  out  1  one-cycle pulse when START is rejected for invalid BCD.

Behaviour:
- Clocking/reset:
  - One clock; reset is synchronous and active-low.
  - RSTN low at an edge forces state=ABORT, presc=0, preset_r=00, reload_r=0, ERR=0.
  - While in reset, outputs are CLR=1 and all others 0. First cycle after release is ABORT, then IDLE.
- Output timing: all outputs decode only registered state; there is no combinational input-to-output path.
- States:
  - IDLE: all strobes 0.
    - STOP -> ABORT.
    - START with both nibbles <=9 -> LOAD; latch preset_r=PRESET and reload_r=AUTO_RELOAD.
    - START with any nibble >9 -> ERR=1 for the next cycle; stay IDLE; preset_r unchanged.
  - LOAD: LD=1, D=preset_r, presc cleared -> RUN.
  - RUN: EN=1; presc increments, wrapping at PRESCALE-1; CAI=1 when presc==PRESCALE-1.
    - CAO sampled high -> EXPIRE (on the same edge the counter wraps 00->99).
    - Otherwise PAUSE -> HOLD. Pause takes effect the cycle after sampling, so one final CAI may issue.
  - HOLD: EN=0, CAI=0, presc frozen. PAUSE low -> RUN with presc resumed.
  - EXPIRE: DONE=1.
    - reload_r=1: LD=1, presc cleared -> RUN.
    - reload_r=0: CLR=1 -> IDLE.
  - ABORT: CLR=1 -> IDLE.
- Priority in every state except reset: STOP > valid START > CAO/PAUSE.
  - STOP from any state -> ABORT.
  - Valid START in RUN, HOLD or EXPIRE -> LOAD with a re-latch of PRESET/AUTO_RELOAD, abandoning the current count.
  - Invalid START in those states -> ERR pulse; current operation continues.
- Timing:
  - START sampled at edge k -> LD high in cycle k+1 -> RUN from cycle k+2.
  - First CAI occurs PRESCALE cycles after RUN entry.
  - For preset value n (decimal), DONE occurs (n+1)*PRESCALE cycles after RUN entry.
  - Auto-reload period is (n+1)*PRESCALE+1 cycles.
- Boundary cases:
  - Preset 00: the first tick carries out, so DONE follows PRESCALE cycles after RUN entry.
  - PRESCALE=1: CAI high on every RUN cycle.
  - CAO sampled outside RUN is ignored.
  - BUSY=1 in LOAD, RUN, HOLD and EXPIRE.

Decomposition:
- Package cdd_timer_pkg holds:
  - state enum: IDLE, LOAD, RUN, HOLD, EXPIRE, ABORT.
  - function bcd8_valid.
  - localparam for the reset state (ABORT).
- Sub-module cdd_prescale (PRESCALE, PW): synchronous clear, hold, and a terminal-count tick output.
- Bench pairs this block with the BCD down counter; the counter's asynchronous clear input is driven from CLR.

Test Plan:
- Reset/one-shot, PRESCALE=4, PRESET=8'h03, AUTO_RELOAD=0, START one cycle:
  - Q sequence 03,02,01,00 with CAI every 4 cycles.
  - DONE 16 cycles after RUN entry, one CLR pulse, then Q=00, BUSY=0.
- Auto-reload, PRESCALE=2, PRESET=8'h01, AUTO_RELOAD=1:
  - DONE pulses every 5 cycles.
  - Q transient 99 for exactly one cycle after each expiry, then reloaded to 01.
- PAUSE held 7 cycles mid-count at Q=02 -> no CAI, EN=0 and Q held at 02 throughout; DONE delayed by exactly 7 cycles.
- STOP asserted together with START in RUN -> ABORT, CLR=1 one cycle, IDLE, Q=00, no DONE.
- Invalid START: PRESET=8'h3A in IDLE -> ERR one cycle, stays IDLE, LD never asserted.
- Restart: START with PRESET=8'h05 while RUN at Q=02 -> LD next cycle, Q=05, count restarts from presc=0.

Source files
------------

// File: rtl/cdd_timer_pkg.sv
// Shared types and helpers for the BCD countdown timer control stage.
package cdd_timer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    HOLD,
    EXPIRE,
    ABORT
  } state_e;

  localparam state_e RESET_STATE = ABORT;

  function automatic logic bcd8_valid(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

endpackage

// File: rtl/cdd_prescale.sv
// Count-tick prescaler: counts 0..PRESCALE-1 while enabled, flags the last count.
module cdd_prescale #(
  parameter int PRESCALE = 10,
  parameter int PW       = 16
) (
  input  logic clk_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam logic [PW-1:0] TERM = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == TERM) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    cnt_q <= cnt_d;
  end

  assign tick_o = (cnt_q == TERM);

endmodule

// File: rtl/cdd_timer_ctrl.sv
// Countdown timer control for a two-digit BCD down counter: load, tick, pause,
// abort, auto-reload and terminal-count detection via the counter's CAO.
module cdd_timer_ctrl
  import cdd_timer_pkg::*;
#(
  parameter int PRESCALE = 10,
  parameter int PW       = 16
) (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic       START,
  input  logic       STOP,
  input  logic       PAUSE,
  input  logic       AUTO_RELOAD,
  input  logic [7:0] PRESET,
  input  logic       CAO,
  output logic [7:0] D,
  output logic       LD,
  output logic       EN,
  output logic       CAI,
  output logic       CLR,
  output logic       DONE,
  output logic       BUSY,
  output logic       ERR
);

  state_e     state_q;
  logic [7:0] preset_q;
  logic       reload_q;
  logic       err_q;
  logic       tick;
  logic       start_ok;
  logic       start_bad;

  always_comb begin
    start_ok  = 1'b0;
    start_bad = 1'b0;
    if (START && (state_q inside {IDLE, RUN, HOLD, EXPIRE})) begin
      start_ok  = bcd8_valid(PRESET);
      start_bad = !bcd8_valid(PRESET);
    end
  end

  // Prescaler runs only in RUN, freezes in HOLD and restarts from zero otherwise.
  cdd_prescale #(
    .PRESCALE (PRESCALE),
    .PW       (PW)
  ) u_presc (
    .clk_i  (CLK),
    .clr_i  (!RSTN || !(state_q inside {RUN, HOLD})),
    .en_i   (state_q == RUN),
    .tick_o (tick)
  );

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q  <= RESET_STATE;
      preset_q <= 8'h00;
      reload_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (STOP) begin
        state_q <= ABORT;
      end else if (start_ok) begin
        state_q  <= LOAD;
        preset_q <= PRESET;
        reload_q <= AUTO_RELOAD;
      end else begin
        err_q <= start_bad;
        case (state_q)
          IDLE:    state_q <= IDLE;
          LOAD:    state_q <= RUN;
          RUN: begin
            if (CAO)        state_q <= EXPIRE;
            else if (PAUSE) state_q <= HOLD;
          end
          HOLD:    if (!PAUSE) state_q <= RUN;
          EXPIRE:  state_q <= reload_q ? RUN : IDLE;
          ABORT:   state_q <= IDLE;
          default: state_q <= ABORT;
        endcase
      end
    end
  end

  assign D    = preset_q;
  assign LD   = (state_q == LOAD) || ((state_q == EXPIRE) && reload_q);
  assign EN   = (state_q == RUN);
  assign CAI  = (state_q == RUN) && tick;
  assign CLR  = (state_q == ABORT) || ((state_q == EXPIRE) && !reload_q);
  assign DONE = (state_q == EXPIRE);
  assign BUSY = state_q inside {LOAD, RUN, HOLD, EXPIRE};
  assign ERR  = err_q;

endmodule

// File: tb/tb_cdd_timer_ctrl.sv
// Directed bench: two timer controls (PRESCALE 4 and 2) each driving a BCD down counter model.
module tb_cdd_timer_ctrl;

  logic       CLK = 1'b0;
  logic       rstn, start, stop, pause, auto_rl;
  logic [7:0] preset;

  logic [7:0] d4, d2, q4, q2;
  logic       ld4, en4, cai4, clr4, done4, busy4, err4, cao4;
  logic       ld2, en2, cai2, clr2, done2, busy2, err2, cao2;

  int n_vec = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  cdd_timer_ctrl #(.PRESCALE(4), .PW(16)) dut4 (
    .CLK(CLK), .RSTN(rstn), .START(start), .STOP(stop), .PAUSE(pause),
    .AUTO_RELOAD(auto_rl), .PRESET(preset), .CAO(cao4),
    .D(d4), .LD(ld4), .EN(en4), .CAI(cai4), .CLR(clr4),
    .DONE(done4), .BUSY(busy4), .ERR(err4)
  );

  cdd_timer_ctrl #(.PRESCALE(2), .PW(16)) dut2 (
    .CLK(CLK), .RSTN(rstn), .START(start), .STOP(stop), .PAUSE(pause),
    .AUTO_RELOAD(auto_rl), .PRESET(preset), .CAO(cao2),
    .D(d2), .LD(ld2), .EN(en2), .CAI(cai2), .CLR(clr2),
    .DONE(done2), .BUSY(busy2), .ERR(err2)
  );

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v == 8'h00)      return 8'h99;
    if (v[3:0] == 4'h0)  return {v[7:4] - 4'h1, 4'h9};
    return {v[7:4], v[3:0] - 4'h1};
  endfunction

  // BCD down counters with asynchronous clear
  always_ff @(posedge CLK or posedge clr4) begin
    if (clr4)             q4 <= 8'h00;
    else if (ld4)         q4 <= d4;
    else if (en4 && cai4) q4 <= bcd_dec(q4);
  end

  always_ff @(posedge CLK or posedge clr2) begin
    if (clr2)             q2 <= 8'h00;
    else if (ld2)         q2 <= d2;
    else if (en2 && cai2) q2 <= bcd_dec(q2);
  end

  assign cao4 = cai4 && en4 && (q4 == 8'h00);
  assign cao2 = cai2 && en2 && (q2 == 8'h00);

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int eff;
    logic hold;
    rstn = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; auto_rl = 1'b0; preset = 8'h00;

    // Reset: CLR high, every other output low
    step(); step();
    check("reset_outs", {24'h0, d4, ld4, en4, cai4, clr4, done4, busy4, err4},
          {24'h0, 8'h00, 7'b0001000});
    rstn = 1'b1;
    step();
    check("post_reset_clr", {31'h0, clr4}, 32'h0);
    check("post_reset_busy", {31'h0, busy4}, 32'h0);
    check("post_reset_q", {24'h0, q4}, 32'h0);

    // One-shot, PRESCALE=4, preset 03
    preset = 8'h03; auto_rl = 1'b0; start = 1'b1;
    step();
    check("os_ld", {31'h0, ld4}, 32'h1);
    check("os_d", {24'h0, d4}, 32'h03);
    check("os_busy", {31'h0, busy4}, 32'h1);
    start = 1'b0;
    step();
    for (int i = 0; i < 16; i++) begin
      check($sformatf("os_cai_%0d", i), {31'h0, cai4}, {31'h0, ((i % 4) == 3)});
      check($sformatf("os_q_%0d", i), {24'h0, q4}, 32'(3 - i / 4));
      check($sformatf("os_done_%0d", i), {31'h0, done4}, 32'h0);
      step();
    end
    check("os_done", {31'h0, done4}, 32'h1);
    check("os_clr", {31'h0, clr4}, 32'h1);
    step();
    check("os_end_busy", {31'h0, busy4}, 32'h0);
    check("os_end_q", {24'h0, q4}, 32'h0);
    check("os_end_clr", {31'h0, clr4}, 32'h0);

    // Auto-reload, PRESCALE=2, preset 01: period 5, Q=99 for one cycle at expiry
    preset = 8'h01; auto_rl = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    step();
    for (int i = 0; i < 15; i++) begin
      check($sformatf("ar_done_%0d", i), {31'h0, done2}, {31'h0, ((i % 5) == 4)});
      check($sformatf("ar_q_%0d", i), {24'h0, q2},
            ((i % 5) < 2) ? 32'h01 : (((i % 5) < 4) ? 32'h00 : 32'h99));
      step();
    end
    check("ar_reloaded_q", {24'h0, q2}, 32'h01);

    // STOP together with START while running
    stop = 1'b1; start = 1'b1; preset = 8'h05;
    step();
    check("stop_clr", {31'h0, clr2}, 32'h1);
    check("stop_done", {31'h0, done2}, 32'h0);
    check("stop_ld", {31'h0, ld2}, 32'h0);
    check("stop_q", {24'h0, q2}, 32'h0);
    stop = 1'b0; start = 1'b0;
    step();
    check("stop_idle_clr", {31'h0, clr2}, 32'h0);
    check("stop_idle_busy", {31'h0, busy2}, 32'h0);
    check("stop_idle_q", {24'h0, q2}, 32'h0);

    // Pause 7 cycles at Q=02 on PRESCALE=4: DONE moves from 16 to 23
    preset = 8'h03; auto_rl = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    for (int idx = 0; idx < 23; idx++) begin
      hold = (idx >= 5) && (idx <= 11);
      eff  = (idx < 5) ? idx : idx - 7;
      if (hold) begin
        check($sformatf("pz_en_%0d", idx), {31'h0, en4}, 32'h0);
        check($sformatf("pz_cai_%0d", idx), {31'h0, cai4}, 32'h0);
        check($sformatf("pz_q_%0d", idx), {24'h0, q4}, 32'h02);
      end else begin
        check($sformatf("pz_cai_%0d", idx), {31'h0, cai4}, {31'h0, ((eff % 4) == 3)});
        check($sformatf("pz_q_%0d", idx), {24'h0, q4}, 32'(3 - eff / 4));
      end
      check($sformatf("pz_done_%0d", idx), {31'h0, done4}, 32'h0);
      pause = (idx >= 4) && (idx <= 10);
      step();
    end
    check("pz_done", {31'h0, done4}, 32'h1);
    step();
    check("pz_end_busy", {31'h0, busy4}, 32'h0);

    // Invalid START in IDLE
    preset = 8'h3A; start = 1'b1;
    step();
    check("inv_err", {31'h0, err4}, 32'h1);
    check("inv_ld", {31'h0, ld4}, 32'h0);
    check("inv_busy", {31'h0, busy4}, 32'h0);
    start = 1'b0;
    step();
    check("inv_err_clear", {31'h0, err4}, 32'h0);
    check("inv_ld2", {31'h0, ld4}, 32'h0);
    check("inv_d_kept", {24'h0, d4}, 32'h03);

    // Restart with 05 while running at Q=02
    preset = 8'h03; start = 1'b1;
    step();
    start = 1'b0;
    step();
    for (int i = 0; i < 5; i++) step();
    check("rs_q_before", {24'h0, q4}, 32'h02);
    preset = 8'h05; start = 1'b1;
    step();
    check("rs_ld", {31'h0, ld4}, 32'h1);
    check("rs_d", {24'h0, d4}, 32'h05);
    start = 1'b0;
    step();
    check("rs_q_loaded", {24'h0, q4}, 32'h05);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rs_cai_%0d", i), {31'h0, cai4}, {31'h0, (i == 3)});
      step();
    end
    check("rs_q_after_tick", {24'h0, q4}, 32'h04);

    stop = 1'b1;
    step();
    stop = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
